// File: rtl/h3_qmatrix_loader_if.sv
// Handshake and matrix bus between a Q-row source, the loader and the hash stages.
interface h3_qmatrix_loader_if #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH = 12
);
  localparam int unsigned FLAT_W = KEY_WIDTH * INDEX_WIDTH;

  logic                   load_start;
  logic                   row_valid;
  logic [INDEX_WIDTH-1:0] row_data;
  logic                   row_parity;
  logic                   row_ready;
  logic [FLAT_W-1:0]      q_flat;
  logic                   q_valid;
  logic                   load_done;
  logic                   busy;
  logic                   parity_err;

  modport master (
    output load_start, row_valid, row_data, row_parity,
    input  row_ready, q_flat, q_valid, load_done, busy, parity_err
  );

  modport slave (
    input  load_start, row_valid, row_data, row_parity,
    output row_ready, q_flat, q_valid, load_done, busy, parity_err
  );
endinterface

// File: rtl/h3_qmatrix_loader.sv
// Q-matrix writer for the H3 hash: loads KEY_WIDTH rows over valid/ready into a register file.
// Optional row parity checking is enabled with `define QLOAD_PARITY_EN.
module h3_qmatrix_loader #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  h3_qmatrix_loader_if.slave    bus
);
  localparam int unsigned IDX_W  = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam int unsigned FLAT_W = KEY_WIDTH * INDEX_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic                   q_valid, q_valid_n;
  logic                   load_done, load_done_n;
  logic                   parity_err, parity_err_n;
  logic                   wr_en;
  logic                   xfer_c;
  logic                   row_bad_c;
  logic [INDEX_WIDTH-1:0] rows [KEY_WIDTH];
  logic [FLAT_W-1:0]      q_flat_c;

  assign xfer_c = bus.row_valid && (state == LOAD);

`ifdef QLOAD_PARITY_EN
  // Even parity over data plus parity bit must reduce to zero.
  assign row_bad_c = ^{bus.row_data, bus.row_parity};
`else
  assign row_bad_c = 1'b0;
`endif

  // Next-state and next-output logic; a restart always wins over a row transfer.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    q_valid_n    = q_valid;
    load_done_n  = 1'b0;
    parity_err_n = parity_err;
    wr_en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_n      = LOAD;
          idx_n        = '0;
          q_valid_n    = 1'b0;
          parity_err_n = 1'b0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          idx_n        = '0;
          q_valid_n    = 1'b0;
          parity_err_n = 1'b0;
        end else if (xfer_c) begin
          if (row_bad_c) begin
            state_n      = IDLE;
            parity_err_n = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (idx == LAST_IDX) begin
              state_n = DONE;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (bus.load_start) begin
          state_n      = LOAD;
          idx_n        = '0;
          q_valid_n    = 1'b0;
          parity_err_n = 1'b0;
        end else begin
          state_n     = IDLE;
          q_valid_n   = 1'b1;
          load_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      q_valid    <= 1'b0;
      load_done  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      q_valid    <= q_valid_n;
      load_done  <= load_done_n;
      parity_err <= parity_err_n;
    end
  end

  // Row register file; rows not yet rewritten keep their previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(KEY_WIDTH); i++) rows[i] <= '0;
    end else if (wr_en) begin
      rows[idx] <= bus.row_data;
    end
  end

  always_comb begin
    q_flat_c = '0;
    for (int i = 0; i < int'(KEY_WIDTH); i++) begin
      q_flat_c[i*INDEX_WIDTH +: INDEX_WIDTH] = rows[i];
    end
  end

  assign bus.q_flat     = q_flat_c;
  assign bus.q_valid    = q_valid;
  assign bus.load_done  = load_done;
  assign bus.parity_err = parity_err;
  assign bus.row_ready  = (state == LOAD);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_h3_qmatrix_loader.sv
// Self-checking bench for h3_qmatrix_loader with KEY_WIDTH=4, INDEX_WIDTH=12.
module tb_h3_qmatrix_loader;
  localparam int unsigned KW = 4;
  localparam int unsigned IW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  h3_qmatrix_loader_if #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW)) bus ();

  h3_qmatrix_loader #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0][11:0] rows;
    logic [3:0][3:0]  gaps;
    logic [47:0]      exp_q;
    int               exp_lat;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " q_flat"}, 64'(bus.q_flat), 64'h0);
    chk({nm, " q_valid"}, 64'(bus.q_valid), 64'h0);
    chk({nm, " row_ready"}, 64'(bus.row_ready), 64'h0);
    chk({nm, " busy"}, 64'(bus.busy), 64'h0);
    chk({nm, " load_done"}, 64'(bus.load_done), 64'h0);
    chk({nm, " parity_err"}, 64'(bus.parity_err), 64'h0);
  endtask

  // Full load: start (with a stray row that must be ignored), rows with gaps, then measure latency.
  task automatic run_load(input logic [3:0][11:0] r, input logic [3:0][3:0] g,
                          input logic [47:0] exp_q, input int exp_lat, input string nm);
    int   cyc;
    logic seen;
    bus.load_start = 1'b1;
    bus.row_valid  = 1'b1;
    bus.row_data   = 12'h333;
    bus.row_parity = ^bus.row_data;
    @(negedge clk);
    cyc = 1;
    bus.load_start = 1'b0;
    chk({nm, " ready after start"}, 64'(bus.row_ready), 64'h1);
    chk({nm, " busy after start"}, 64'(bus.busy), 64'h1);
    chk({nm, " q_valid cleared"}, 64'(bus.q_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      bus.row_valid = 1'b0;
      for (int k = 0; k < int'(g[i]); k++) begin
        @(negedge clk);
        cyc++;
        chk({nm, " q_valid in gap"}, 64'(bus.q_valid), 64'h0);
      end
      bus.row_valid  = 1'b1;
      bus.row_data   = r[i];
      bus.row_parity = ^r[i];
      @(negedge clk);
      cyc++;
      chk({nm, " row visible"}, 64'(bus.q_flat[i*12 +: 12]), 64'(r[i]));
    end
    bus.row_data   = 12'hFFF;
    bus.row_parity = ^bus.row_data;
    chk({nm, " ready low after last"}, 64'(bus.row_ready), 64'h0);
    chk({nm, " q_valid low before done"}, 64'(bus.q_valid), 64'h0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.load_done) seen = 1'b1;
    end
    chk({nm, " done seen"}, 64'(seen), 64'h1);
    chk({nm, " done latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, " q_valid with done"}, 64'(bus.q_valid), 64'h1);
    chk({nm, " busy with done"}, 64'(bus.busy), 64'h0);
    @(negedge clk);
    chk({nm, " done single pulse"}, 64'(bus.load_done), 64'h0);
    chk({nm, " q_valid holds"}, 64'(bus.q_valid), 64'h1);
    chk({nm, " q_flat"}, 64'(bus.q_flat), 64'(exp_q));
    bus.row_valid = 1'b0;
  endtask

  initial begin
    logic [3:0][11:0] r;
    logic [3:0][3:0]  g;
    logic [47:0]      exp_q;
    int               lat;

    bus.load_start = 1'b0;
    bus.row_valid  = 1'b0;
    bus.row_data   = '0;
    bus.row_parity = 1'b0;

    tbl[0].rows = {12'h008, 12'h004, 12'h002, 12'h001};
    tbl[0].gaps = {4'd0, 4'd0, 4'd0, 4'd0};
    tbl[0].exp_q = 48'h008004002001;
    tbl[0].exp_lat = 6;
    tbl[1].rows = {12'h008, 12'h004, 12'h002, 12'h001};
    tbl[1].gaps = {4'd0, 4'd3, 4'd0, 4'd0};
    tbl[1].exp_q = 48'h008004002001;
    tbl[1].exp_lat = 9;
    tbl[2].rows = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};
    tbl[2].gaps = {4'd1, 4'd0, 4'd2, 4'd0};
    tbl[2].exp_q = 48'hDDDCCCBBBAAA;
    tbl[2].exp_lat = 9;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_reset_outputs("idle");
    end

    for (int t = 0; t < 3; t++) begin
      run_load(tbl[t].rows, tbl[t].gaps, tbl[t].exp_q, tbl[t].exp_lat, $sformatf("vec%0d", t));
    end

    // Restart mid-load with a row offered in the restart cycle: that row is dropped.
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.row_valid = 1'b1;
    bus.row_data = 12'h111;
    bus.row_parity = ^bus.row_data;
    @(negedge clk);
    bus.row_data = 12'h222;
    bus.row_parity = ^bus.row_data;
    @(negedge clk);
    chk("restart pre row1", 64'(bus.q_flat[12 +: 12]), 64'h222);
    run_load({12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA}, '0, 48'hDDDCCCBBBAAA, 6, "restart");

    // Random loads against an arithmetic model: rows land in slice i, latency = 6 + gap cycles.
    for (int n = 0; n < 6; n++) begin
      lat = 6;
      for (int i = 0; i < 4; i++) begin
        r[i] = 12'($urandom);
        g[i] = 4'($urandom_range(0, 3));
        lat += int'(g[i]);
        exp_q[i*12 +: 12] = r[i];
      end
      run_load(r, g, exp_q, lat, $sformatf("rand%0d", n));
    end

    // q_valid falls on restart; reset mid-load returns everything to reset values.
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("reload q_valid falls", 64'(bus.q_valid), 64'h0);
    bus.row_valid = 1'b1;
    bus.row_data = 12'h5A5;
    bus.row_parity = ^bus.row_data;
    @(negedge clk);
    chk("reload row0", 64'(bus.q_flat[11:0]), 64'h5A5);
    rst = 1'b1;
    bus.row_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("rst mid-load");

    // load_start during DONE cancels the completion.
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.row_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.row_data = 12'(12'h101 * (i + 1));
      bus.row_parity = ^bus.row_data;
      @(negedge clk);
    end
    bus.row_valid = 1'b0;
    chk("cancel in DONE state", 64'({bus.busy, bus.row_ready}), 64'h2);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("cancel no done", 64'(bus.load_done), 64'h0);
    chk("cancel q_valid", 64'(bus.q_valid), 64'h0);
    chk("cancel back in LOAD", 64'(bus.row_ready), 64'h1);
    @(negedge clk);
    chk("cancel no late done", 64'(bus.load_done), 64'h0);
    chk("cancel q_valid stays", 64'(bus.q_valid), 64'h0);

    // Row with bad parity (0x003 has even weight, parity bit 1).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.row_valid = 1'b1;
    bus.row_data = 12'h003;
    bus.row_parity = 1'b1;
    @(negedge clk);
    bus.row_valid = 1'b0;
    bus.row_parity = 1'b0;
`ifdef QLOAD_PARITY_EN
    chk("parity err set", 64'(bus.parity_err), 64'h1);
    chk("parity busy", 64'(bus.busy), 64'h0);
    chk("parity q_valid", 64'(bus.q_valid), 64'h0);
    chk("parity row not written", 64'(bus.q_flat[11:0]), 64'h0);
    @(negedge clk);
    chk("parity err sticky", 64'(bus.parity_err), 64'h1);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("parity err cleared", 64'(bus.parity_err), 64'h0);
`else
    chk("no parity err", 64'(bus.parity_err), 64'h0);
    chk("no parity busy", 64'(bus.busy), 64'h1);
    chk("no parity row written", 64'(bus.q_flat[11:0]), 64'h003);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
